// File: rtl/io_pkg.sv
// Shared definitions for the IO-window crossbar: FSM encodings, error
// causes and the system IO map that top level folds into SLV_BASE/SLV_MASK.
package io_pkg;

  // Crossbar FSM encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Error causes reported in err_code
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // IO map: word-address bases and compare masks (1 = bit compared)
  localparam int unsigned IO_ADDR_W  = 6;
  localparam int unsigned IO_NUM_DEV = 6;

  localparam logic [IO_ADDR_W-1:0] DEV_UART_BASE    = 6'h00;
  localparam logic [IO_ADDR_W-1:0] DEV_UART_MASK    = 6'h3C;
  localparam logic [IO_ADDR_W-1:0] DEV_TIMER_BASE   = 6'h04;
  localparam logic [IO_ADDR_W-1:0] DEV_TIMER_MASK   = 6'h3C;
  localparam logic [IO_ADDR_W-1:0] DEV_GPIO_BASE    = 6'h08;
  localparam logic [IO_ADDR_W-1:0] DEV_GPIO_MASK    = 6'h38;
  localparam logic [IO_ADDR_W-1:0] DEV_SPI_BASE     = 6'h10;
  localparam logic [IO_ADDR_W-1:0] DEV_SPI_MASK     = 6'h3C;
  localparam logic [IO_ADDR_W-1:0] DEV_I2C_BASE     = 6'h14;
  localparam logic [IO_ADDR_W-1:0] DEV_I2C_MASK     = 6'h3C;
  localparam logic [IO_ADDR_W-1:0] DEV_SYSCTRL_BASE = 6'h3C;
  localparam logic [IO_ADDR_W-1:0] DEV_SYSCTRL_MASK = 6'h3C;

  // Slice i belongs to slave i, so the highest index is leftmost
  localparam logic [IO_NUM_DEV*IO_ADDR_W-1:0] IO_SLV_BASE = {
    DEV_SYSCTRL_BASE, DEV_I2C_BASE, DEV_SPI_BASE,
    DEV_GPIO_BASE, DEV_TIMER_BASE, DEV_UART_BASE
  };
  localparam logic [IO_NUM_DEV*IO_ADDR_W-1:0] IO_SLV_MASK = {
    DEV_SYSCTRL_MASK, DEV_I2C_MASK, DEV_SPI_MASK,
    DEV_GPIO_MASK, DEV_TIMER_MASK, DEV_UART_MASK
  };

endpackage

// File: rtl/io_xbar_dec.sv
// Combinational priority address decoder: lowest-index matching slave wins.
module io_xbar_dec
  import io_pkg::*;
#(
  parameter int unsigned NUM_SLV = 16,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned SEL_W   = 4
) (
  input  logic [ADDR_W-1:0]         addr,
  input  logic [NUM_SLV*ADDR_W-1:0] bases,
  input  logic [NUM_SLV*ADDR_W-1:0] masks,
  output logic [SEL_W-1:0]          sel,
  output logic                      sel_valid
);

  // Scan from the top down so the lowest matching index is written last
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    for (int unsigned i = NUM_SLV; i > 0; i--) begin
      if (((addr ^ bases[(i-1)*ADDR_W +: ADDR_W]) & masks[(i-1)*ADDR_W +: ADDR_W]) == '0) begin
        sel       = SEL_W'(i - 1);
        sel_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_xbar.sv
// IO-window crossbar: decodes the word address to one slave strobe, muxes
// read data and ack back, and forces an ack (with an error record) for
// unmapped addresses and slaves that never answer.
module io_xbar
  import io_pkg::*;
#(
  parameter int unsigned                    NUM_SLV     = 16,
  parameter int unsigned                    ADDR_W      = 6,
  parameter logic [NUM_SLV*ADDR_W-1:0]      SLV_BASE    = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0]      SLV_MASK    = '1,
  parameter int unsigned                    TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stb,
  input  logic [ADDR_W-1:0]       addr,
  output logic [NUM_SLV-1:0]      slv_stb,
  input  logic [NUM_SLV-1:0]      slv_ack,
  input  logic [NUM_SLV*32-1:0]   slv_dout,
  output logic [31:0]             data_out,
  output logic                    ack,
  output logic                    err_trig,
  output logic [1:0]              err_code,
  output logic [ADDR_W-1:0]       err_addr,
  input  logic                    err_clr
);

  localparam int unsigned SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic [SEL_W-1:0]  dec_sel;
  logic              dec_valid;
  logic [SEL_W-1:0]  cur_sel;
  logic              cur_valid;
  logic              in_wait, in_done;
  logic              active;
  logic              sel_ack;
  logic [31:0]       sel_dout;
  logic              go_done;
  logic [1:0]        cause;

  io_xbar_dec #(
    .NUM_SLV (NUM_SLV),
    .ADDR_W  (ADDR_W),
    .SEL_W   (SEL_W)
  ) u_dec (
    .addr      (addr),
    .bases     (SLV_BASE),
    .masks     (SLV_MASK),
    .sel       (dec_sel),
    .sel_valid (dec_valid)
  );

  assign in_wait = (state_q == S_WAIT);
  assign in_done = (state_q == S_DONE);

  // While waiting, the slave chosen on leaving IDLE stays selected (WAIT is
  // only entered on a valid decode), so address wobble cannot retarget it.
  assign cur_sel   = in_wait ? sel_q : dec_sel;
  assign cur_valid = in_wait | dec_valid;
  assign active    = stb & cur_valid & ~in_done;

  // Strobe fan-out and ack/data selection for the current target
  always_comb begin
    slv_stb  = '0;
    sel_ack  = 1'b0;
    sel_dout = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (cur_sel == SEL_W'(i)) begin
        slv_stb[i] = active;
        sel_ack    = slv_ack[i];
        sel_dout   = slv_dout[i*32 +: 32];
      end
    end
  end

  assign data_out = active ? sel_dout : 32'h0;
  assign ack      = (active & sel_ack) | in_done;
  assign err_trig = in_done;
  assign err_code = err_code_q;
  assign err_addr = err_addr_q;

  // Next-state logic for FSM, timeout counter and latched request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    go_done = 1'b0;
    cause   = ERR_NONE;
    case (state_q)
      S_IDLE: begin
        if (stb) begin
          if (!dec_valid) begin
            state_d = S_DONE;
            addr_d  = addr;
            go_done = 1'b1;
            cause   = ERR_UNMAPPED;
          end else if (!sel_ack) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
            sel_d   = dec_sel;
            addr_d  = addr;
          end
        end
      end
      S_WAIT: begin
        if (!stb || sel_ack) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
          state_d = S_DONE;
          cnt_d   = '0;
          go_done = 1'b1;
          cause   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sticky error record; a new error takes priority over a same-cycle clear
  always_comb begin
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    if (go_done) begin
      err_code_d = cause;
      err_addr_d = addr_d;
    end else if (err_clr) begin
      err_code_d = ERR_NONE;
      err_addr_d = '0;
    end
  end

  // State and error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      addr_q     <= '0;
      err_code_q <= ERR_NONE;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_io_xbar.sv
// Self-checking bench for io_xbar: directed scenarios followed by random
// transactions, checked against a transaction-level model of the crossbar.
module tb_io_xbar;
  import io_pkg::*;

  localparam int NS    = 4;
  localparam int TMO   = 8;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          stb;
  logic [5:0]    addr;
  logic [NS-1:0] slv_stb;
  logic [NS-1:0] slv_ack;
  logic [NS*32-1:0] slv_dout;
  logic [31:0]   data_out;
  logic          ack;
  logic          err_trig;
  logic [1:0]    err_code;
  logic [5:0]    err_addr;
  logic          err_clr;

  int n_assert = 0;
  int n_fail   = 0;

  // Slave table as seen by the bench
  logic [5:0] tb_base [NS] = '{6'h10, 6'h28, 6'h31, 6'h2A};
  logic [5:0] tb_mask [NS] = '{6'h3F, 6'h3C, 6'h3F, 6'h3F};
  int lat  [NS];
  int scnt [NS];

  // Expected error record
  logic [1:0] m_code;
  logic [5:0] m_addr;

  io_xbar #(
    .NUM_SLV     (NS),
    .ADDR_W      (6),
    .SLV_BASE    ({6'h2A, 6'h31, 6'h28, 6'h10}),
    .SLV_MASK    ({6'h3F, 6'h3F, 6'h3C, 6'h3F}),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stb      (stb),
    .addr     (addr),
    .slv_stb  (slv_stb),
    .slv_ack  (slv_ack),
    .slv_dout (slv_dout),
    .data_out (data_out),
    .ack      (ack),
    .err_trig (err_trig),
    .err_code (err_code),
    .err_addr (err_addr),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  assign slv_dout = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};

  // Behavioural slaves: ack once the strobe has been held lat[i] cycles
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) scnt[i] <= slv_stb[i] ? scnt[i] + 1 : 0;
  end

  always @* begin
    for (int i = 0; i < NS; i++)
      slv_ack[i] = slv_stb[i] && (lat[i] < NEVER) && (scnt[i] >= lat[i]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int target(input logic [5:0] a);
    for (int i = 0; i < NS; i++)
      if (((a ^ tb_base[i]) & tb_mask[i]) == 6'h0) return i;
    return -1;
  endfunction

  // One CPU access; clr_cyc selects a cycle in which err_clr is held high
  task automatic run_txn(input logic [5:0] a, input int clr_cyc);
    int tgt, exp_cyc, cyc;
    logic [31:0] exp_data, exp_stb;
    logic [1:0]  exp_err;
    bit got;
    tgt = target(a);
    exp_stb = '0;
    if (tgt < 0) begin
      exp_cyc = 1; exp_data = 32'h0; exp_err = ERR_UNMAPPED;
    end else begin
      exp_stb = 32'h1 << tgt;
      if (lat[tgt] <= TMO) begin
        exp_cyc = lat[tgt]; exp_data = 32'hCAFE0000 + 32'(tgt); exp_err = ERR_NONE;
      end else begin
        exp_cyc = TMO + 1; exp_data = 32'h0; exp_err = ERR_TIMEOUT;
      end
    end
    @(negedge clk);
    stb = 1'b1; addr = a; cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      err_clr = (cyc == clr_cyc);
      #2;
      if (cyc == 0) chk("slv_stb", 32'(slv_stb), exp_stb);
      if (ack) begin
        got = 1'b1;
        if (exp_err != ERR_NONE) begin m_code = exp_err; m_addr = a; end
        chk("ack_cycle", 32'(cyc), 32'(exp_cyc));
        chk("data_out", data_out, exp_data);
        chk("err_trig", 32'(err_trig), 32'(exp_err != ERR_NONE));
        chk("err_code", 32'(err_code), 32'(m_code));
        chk("err_addr", 32'(err_addr), 32'(m_addr));
      end else begin
        chk("err_trig_idle", 32'(err_trig), 32'h0);
        @(negedge clk);
        cyc++;
      end
    end
    if (!got) chk("ack_seen", 32'(ack), 32'h1);
    @(negedge clk);
    stb = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    #2;
    chk("state_idle", 32'(dut.state_q), 32'(S_IDLE));
    chk("cnt_zero", 32'(dut.cnt_q), 32'h0);
    chk("err_code_hold", 32'(err_code), 32'(m_code));
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #2;
    m_code = ERR_NONE; m_addr = '0;
    chk("clr_code", 32'(err_code), 32'(m_code));
    chk("clr_addr", 32'(err_addr), 32'(m_addr));
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; addr = '0; err_clr = 1'b0;
    m_code = ERR_NONE; m_addr = '0;
    lat = '{NEVER, 3, 0, 0};
    repeat (2) @(negedge clk);
    #2;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err_trig", 32'(err_trig), 32'h0);
    chk("rst_err_code", 32'(err_code), 32'h0);
    chk("rst_err_addr", 32'(err_addr), 32'h0);
    chk("rst_slv_stb", 32'(slv_stb), 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Combinational ack, delayed ack, timeout, unmapped
    run_txn(6'h31, -1);
    run_txn(6'h29, -1);
    run_txn(6'h10, -1);
    run_txn(6'h05, -1);
    // Clear coinciding with DONE entry: the new error must survive
    run_txn(6'h10, TMO);
    run_txn(6'h05, 0);
    pulse_clr();
    // Overlapping decode: slave 1 beats slave 3
    run_txn(6'h2A, -1);

    // Reset in cycle 4 of a WAIT
    @(negedge clk); stb = 1'b1; addr = 6'h10;
    repeat (4) @(negedge clk);
    #2;
    chk("pre_rst_wait", 32'(dut.state_q), 32'(S_WAIT));
    rst = 1'b1;
    #1;
    chk("rst_mid_ack", 32'(ack), 32'h0);
    chk("rst_mid_state", 32'(dut.state_q), 32'(S_IDLE));
    @(negedge clk); stb = 1'b0;
    @(negedge clk); rst = 1'b0;
    m_code = ERR_NONE; m_addr = '0;
    #2;
    chk("post_rst_code", 32'(err_code), 32'h0);
    chk("post_rst_ack", 32'(ack), 32'h0);
    chk("post_rst_state", 32'(dut.state_q), 32'(S_IDLE));
    run_txn(6'h31, -1);

    // Random accesses with random slave latencies
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NS; i++) begin
        lat[i] = int'($urandom_range(0, 12));
        if (lat[i] == 12) lat[i] = NEVER;
      end
      run_txn(6'($urandom_range(0, 63)), -1);
      if ($urandom_range(0, 3) == 0) pulse_clr();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
